util_upack2_timestamp: RTL and testbench
========================================

# util_upack2_timestamp

Transmit-side counterpart of the ADC timestamp inserter: it sits in the `dac_clk` domain between the DMA read FIFO and `util_upack2`. Incoming packed words are grouped into blocks, each preceded by a 64-bit timestamp header. The block holds each block's samples until the free-running DAC timestamp reaches the header value, then releases them. Late blocks are dropped and counted; with timestamping disabled the block is a pure pass-through.

## Interface
Parameters:
- `DATA_WIDTH`, 64: packed word width; must be ≥ 64 so that a header fits in one word.

Ports:
- `dac_clk` in 1: sole clock.
- `dac_rst` in 1: reset, synchronous, active-high.
- `timestamp` in 64: current DAC sample time; increments once per sample cycle.
- `timestamp_every` in 32: sample words per block; 0 disables timestamping.
- `s_data` in DATA_WIDTH: packed word from the DMA read FIFO.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: word accepted when `s_valid && s_ready`.
- `m_data` out DATA_WIDTH: word presented to `util_upack2`.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: downstream accepts on `m_valid && m_ready`.
- `underflow` out 1: one-cycle pulse; the downstream wanted data during release but none was available.
- `late` out 1: one-cycle pulse; a header was already in the past when accepted.
- `late_count` out 32: number of dropped blocks; saturates at all-ones.
- `waiting` out 1: high while a block is held in WAIT.

## Operation
- State machine states: HDR, WAIT, PASS, DROP, BYP. Reset state is HDR.
- HDR:
  - `s_ready`=1, `m_valid`=0.
  - If `timestamp_every`==0, go to BYP with no word consumed.
  - On a handshake:
    - Latch `hdr_ts`=`s_data[63:0]`.
    - Load `words_left`=`timestamp_every`.
    - If `hdr_ts < timestamp` (unsigned, same cycle): pulse `late`, increment `late_count`, go to DROP.
    - Otherwise go to WAIT.
- WAIT:
  - `s_ready`=0, `m_valid`=0, `waiting`=1.
  - A registered flag `due` is set when `timestamp >= hdr_ts`.
  - Go to PASS on the cycle after `due` is set.
- PASS:
  - Combinational forward: `m_data`=`s_data`, `m_valid`=`s_valid`, `s_ready`=`m_ready`.
  - Each handshake decrements `words_left`. The handshake that takes it from 1 to 0 returns the block to HDR.
  - `m_ready && !s_valid` pulses `underflow`. The block does not abort; its samples are released late.
- DROP:
  - `s_ready`=1, `m_valid`=0.
  - Consumes `words_left` words, then returns to HDR.
- BYP:
  - Same forward as PASS, with no counting.
  - When `timestamp_every` becomes nonzero, go to HDR. The switch is taken only on a cycle with no handshake.
- `timestamp_every` is sampled only when a header is accepted. Changing it mid-block has no effect on the current block.
- Width rules:
  - `words_left` is 32-bit.
  - Only `s_data[63:0]` carries the header; any upper bits are ignored.
  - The comparison is 64-bit unsigned, with no wrap handling; the 64-bit timestamp is assumed never to wrap.
- Reset mid-operation:
  - Returns to HDR and clears `hdr_ts`, `words_left`, `due` and `late_count`.
  - The next accepted word is treated as a header. The upstream FIFO must be reset together with this block to keep framing aligned.

## Timing
- Reset values: `m_valid`=0, `underflow`=0, `late`=0, `late_count`=0, `waiting`=0, `m_data`=0. `s_ready`=1, because the reset state is HDR.
- Header accept at cycle h with `hdr_ts` > `timestamp`:
  - `waiting`=1 from h+1.
  - If `timestamp`==`hdr_ts` at cycle k, `due` registers at k+1, PASS starts at k+2, and the first `m_valid` is at k+2.
- Header equal to `timestamp` at acceptance is not late. It is released at h+3.
- The header word is never forwarded.
- PASS and BYP add zero latency, and throughput is one word per cycle.
- `timestamp_every`=1: one header, then one data word, alternating.
- Simultaneous `late` and `late_count` saturation: `late` still pulses and the counter holds.

## Structure
- Package `util_upack2_timestamp_pkg` holds:
  - the state enum {HDR, WAIT, PASS, DROP, BYP};
  - `TS_WIDTH`=64;
  - `CNT_WIDTH`=32.
- Single module with no sub-module. The registered compare stays inline.

## Test plan
- Bypass: `timestamp_every`=0, stream words 1..12 with `m_ready`=1 → the same 12 words appear on the same cycles and `late_count`=0.
- On-time block: `timestamp_every`=4, `timestamp`=100, send header 110 then words A..D:
  - `s_ready` stays low until release;
  - the first `m_valid` is 2 cycles after `timestamp`==110;
  - A..D are output in order;
  - the header is never output.
- Late block: `timestamp`=200, header 150 followed by 4 words → `late` pulses once, `late_count`=1, nothing is output, and the next header is parsed correctly.
- Underflow and backpressure: during PASS, hold `s_valid` low for 3 cycles with `m_ready`=1 → `underflow` pulses 3 times. Toggle `m_ready` → every word is delivered exactly once.
- Mode change mid-block: set `timestamp_every` from 4 to 2 after the second data word → the current block still passes 4 words, and the next block has 2.
- Reset during WAIT → all outputs return to their reset values and the next word is treated as a header.

Source files
------------

// File: rtl/util_upack2_timestamp_pkg.sv
// Shared types and widths for the DAC-side timestamp release block.
// The state enum is shared so the bench and any wrapper can decode state_q if needed.
package util_upack2_timestamp_pkg;

  localparam int TS_WIDTH  = 64;
  localparam int CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    WAIT = 3'd1,
    PASS = 3'd2,
    DROP = 3'd3,
    BYP  = 3'd4
  } state_e;

endpackage

// File: rtl/util_upack2_timestamp.sv
// Holds DMA blocks until the DAC timestamp reaches each block's header, then
// releases them with zero added latency; late blocks are dropped and counted.
module util_upack2_timestamp
  import util_upack2_timestamp_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  dac_clk,
  input  logic                  dac_rst,
  input  logic [TS_WIDTH-1:0]   timestamp,
  input  logic [CNT_WIDTH-1:0]  timestamp_every,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  underflow,
  output logic                  late,
  output logic [CNT_WIDTH-1:0]  late_count,
  output logic                  waiting
);

  state_e               state_q, state_d;
  logic [TS_WIDTH-1:0]  hdr_ts_q, hdr_ts_d;
  logic [CNT_WIDTH-1:0] words_left_q, words_left_d;
  logic [CNT_WIDTH-1:0] late_count_q, late_count_d;
  logic                 due_q, due_d;
  logic                 late_q, late_d;
  logic                 underflow_q, underflow_d;
  logic                 hs;

  // Datapath steering: PASS and BYP forward the stream combinationally.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    case (state_q)
      // A zero block size must not swallow a word on the way to BYP.
      HDR:       s_ready = (timestamp_every != '0);
      PASS, BYP: begin
        m_data  = s_data;
        m_valid = s_valid;
        s_ready = m_ready;
      end
      DROP:      s_ready = 1'b1;
      default:   s_ready = 1'b0;
    endcase
  end

  assign hs = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    hdr_ts_d     = hdr_ts_q;
    words_left_d = words_left_q;
    late_count_d = late_count_q;
    due_d        = 1'b0;
    late_d       = 1'b0;
    underflow_d  = 1'b0;
    case (state_q)
      HDR: begin
        if (timestamp_every == '0) begin
          state_d = BYP;
        end else if (hs) begin
          hdr_ts_d     = s_data[TS_WIDTH-1:0];
          words_left_d = timestamp_every;
          if (s_data[TS_WIDTH-1:0] < timestamp) begin
            late_d = 1'b1;
            if (late_count_q != '1) late_count_d = late_count_q + 1'b1;
            state_d = DROP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (due_q) state_d = PASS;
        else       due_d   = (timestamp >= hdr_ts_q);
      end
      PASS: begin
        underflow_d = m_ready && !s_valid;
        if (hs) begin
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == 32'd1) state_d = HDR;
        end
      end
      DROP: begin
        if (hs) begin
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == 32'd1) state_d = HDR;
        end
      end
      BYP: begin
        // Leave only between words so no beat is split across modes.
        if ((timestamp_every != '0) && !hs) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_q      <= HDR;
      hdr_ts_q     <= '0;
      words_left_q <= '0;
      late_count_q <= '0;
      due_q        <= 1'b0;
      late_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_ts_q     <= hdr_ts_d;
      words_left_q <= words_left_d;
      late_count_q <= late_count_d;
      due_q        <= due_d;
      late_q       <= late_d;
      underflow_q  <= underflow_d;
    end
  end

  assign underflow  = underflow_q;
  assign late       = late_q;
  assign late_count = late_count_q;
  assign waiting    = (state_q == WAIT);

endmodule

// File: tb/tb_util_upack2_timestamp.sv
// Directed bench for util_upack2_timestamp: bypass, on-time, late, underflow,
// mode change and reset scenarios with hand-computed expectations.
module tb_util_upack2_timestamp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ts  = 64'd0;
  logic [31:0] tse = 32'd4;
  logic [63:0] s_data = 64'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        underflow;
  logic        late;
  logic [31:0] late_count;
  logic        waiting;

  int n_checks = 0;
  int n_fail   = 0;

  util_upack2_timestamp #(.DATA_WIDTH(64)) dut (
    .dac_clk        (clk),
    .dac_rst        (rst),
    .timestamp      (ts),
    .timestamp_every(tse),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .underflow      (underflow),
    .late           (late),
    .late_count     (late_count),
    .waiting        (waiting)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ts = ts + 64'd1;
  endtask

  task automatic do_reset(input logic [31:0] every);
    rst = 1'b1; tse = every; s_valid = 1'b0; m_ready = 1'b0; s_data = 64'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'd4);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b want 0", underflow); end
    n_checks++; if (late !== 1'b0) begin n_fail++; $display("FAIL reset_late got %b want 0", late); end
    n_checks++; if (late_count !== 32'd0) begin n_fail++; $display("FAIL reset_late_count got %0d want 0", late_count); end
    n_checks++; if (waiting !== 1'b0) begin n_fail++; $display("FAIL reset_waiting got %b want 0", waiting); end
    n_checks++; if (m_data !== 64'd0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_bypass();
    do_reset(32'd0);
    m_ready = 1'b1;
    tick();
    for (int i = 1; i <= 12; i++) begin
      s_data = 64'(i); s_valid = 1'b1;
      #1;
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL byp_m_valid[%0d] got %b want 1", i, m_valid); end
      n_checks++; if (m_data !== 64'(i)) begin n_fail++; $display("FAIL byp_m_data[%0d] got %0d want %0d", i, m_data, i); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL byp_s_ready[%0d] got %b want 1", i, s_ready); end
      tick();
    end
    s_valid = 1'b0;
    #1;
    n_checks++; if (late_count !== 32'd0) begin n_fail++; $display("FAIL byp_late_count got %0d want 0", late_count); end
  endtask

  task automatic test_on_time();
    do_reset(32'd4);
    ts = 64'd100; s_data = 64'd110; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ot_hdr_s_ready got %b want 1", s_ready); end
    tick();
    s_data = 64'hA;
    // ts runs 101..111 while held; release expected at ts==112
    for (int c = 0; c < 11; c++) begin
      #1;
      n_checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || waiting !== 1'b1) begin
        n_fail++; $display("FAIL ot_wait[ts=%0d] s_ready=%b m_valid=%b waiting=%b want 0 0 1", ts, s_ready, m_valid, waiting);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      s_data = 64'hA + 64'(i);
      #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 64'hA + 64'(i)) begin
        n_fail++; $display("FAIL ot_word[%0d] m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, 64'hA + 64'(i));
      end
      tick();
    end
    s_valid = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || waiting !== 1'b0) begin
      n_fail++; $display("FAIL ot_end m_valid=%b s_ready=%b waiting=%b want 0 1 0", m_valid, s_ready, waiting);
    end
  endtask

  task automatic test_late();
    do_reset(32'd4);
    ts = 64'd200; s_data = 64'd150; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      s_data = 64'h50 + 64'(i);
      #1;
      n_checks++; if (late !== (i == 0)) begin n_fail++; $display("FAIL late_pulse[%0d] got %b want %b", i, late, (i == 0)); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL late_m_valid[%0d] got %b want 0", i, m_valid); end
      tick();
    end
    n_checks++; if (late_count !== 32'd1) begin n_fail++; $display("FAIL late_count got %0d want 1", late_count); end
    s_data = ts; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    #1;
    n_checks++; if (waiting !== 1'b1 || late !== 1'b0) begin n_fail++; $display("FAIL late_next_hdr waiting=%b late=%b want 1 0", waiting, late); end
    tick();
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL late_h2 m_valid got %b want 0", m_valid); end
    tick();
    s_data = 64'h77; s_valid = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b1 || m_data !== 64'h77) begin n_fail++; $display("FAIL late_h3 m_valid=%b m_data=%h want 1 77", m_valid, m_data); end
  endtask

  task automatic test_underflow();
    logic [8:0] sv_t;
    logic [8:0] mr_t;
    int tx, rx, uf;
    sv_t = 9'b111110001;
    mr_t = 9'b110101111;
    tx = 0; rx = 0; uf = 0;
    do_reset(32'd4);
    ts = 64'd50; s_data = 64'd50; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    for (int p = 0; p < 9; p++) begin
      s_valid = sv_t[p]; m_ready = mr_t[p]; s_data = 64'h1000 + 64'(tx);
      #1;
      if (underflow === 1'b1) uf++;
      n_checks++; if (s_ready !== mr_t[p] || m_valid !== sv_t[p]) begin
        n_fail++; $display("FAIL uf_fwd[%0d] s_ready=%b m_valid=%b want %b %b", p, s_ready, m_valid, mr_t[p], sv_t[p]);
      end
      if (m_valid && m_ready) begin
        n_checks++; if (m_data !== 64'h1000 + 64'(rx)) begin n_fail++; $display("FAIL uf_word[%0d] got %h want %h", rx, m_data, 64'h1000 + 64'(rx)); end
        rx++;
      end
      tick();
      if (sv_t[p] && mr_t[p]) tx++;
    end
    s_valid = 1'b0;
    #1;
    if (underflow === 1'b1) uf++;
    n_checks++; if (uf != 3) begin n_fail++; $display("FAIL uf_count got %0d want 3", uf); end
    n_checks++; if (rx != 4) begin n_fail++; $display("FAIL uf_delivered got %0d want 4", rx); end
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL uf_end m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
  endtask

  task automatic test_mode_change();
    do_reset(32'd4);
    ts = 64'd300; s_data = 64'd300; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      s_data = 64'h2000 + 64'(i); s_valid = 1'b1;
      #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 64'h2000 + 64'(i)) begin
        n_fail++; $display("FAIL mc_blk1[%0d] m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, 64'h2000 + 64'(i));
      end
      tick();
      if (i == 1) tse = 32'd2;
    end
    s_data = ts; s_valid = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL mc_hdr2 m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      s_data = 64'h2100 + 64'(i); s_valid = 1'b1;
      #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 64'h2100 + 64'(i)) begin
        n_fail++; $display("FAIL mc_blk2[%0d] m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, 64'h2100 + 64'(i));
      end
      tick();
    end
    #1;
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL mc_blk2_end m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
  endtask

  task automatic test_reset_wait();
    do_reset(32'd4);
    ts = 64'd1000; s_data = 64'd2000; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (waiting !== 1'b1) begin n_fail++; $display("FAIL rw_waiting got %b want 1", waiting); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (waiting !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 64'd0 || late !== 1'b0 || underflow !== 1'b0 || late_count !== 32'd0) begin
      n_fail++; $display("FAIL rw_outputs waiting=%b s_ready=%b m_valid=%b m_data=%h late=%b underflow=%b late_count=%0d want 0 1 0 0 0 0 0",
                         waiting, s_ready, m_valid, m_data, late, underflow, late_count);
    end
    s_data = ts; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    #1;
    n_checks++; if (waiting !== 1'b1) begin n_fail++; $display("FAIL rw_new_hdr waiting got %b want 1", waiting); end
    tick();
    tick();
    s_data = 64'h3333; s_valid = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b1 || m_data !== 64'h3333) begin n_fail++; $display("FAIL rw_release m_valid=%b m_data=%h want 1 3333", m_valid, m_data); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_on_time();
    test_late();
    test_underflow();
    test_mode_change();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
